// File: rtl/io_spi_cdce_target_if.sv
// SPI wire bundle shared by the CDCE initialiser and its loopback target.
interface io_spi_cdce_target_if;
  logic spi_sclk;
  logic spi_sdata;
  logic spi_n_en;
  logic spi_miso;

  modport master (
    output spi_sclk,
    output spi_sdata,
    output spi_n_en,
    input  spi_miso
  );

  modport slave (
    input  spi_sclk,
    input  spi_sdata,
    input  spi_n_en,
    output spi_miso
  );
endinterface

// File: rtl/io_spi_cdce_target.sv
// SPI target modelling the CDCE register file: decodes 32-bit write
// frames, holds the register image and serves readback on MISO.
module io_spi_cdce_target #(
  parameter int unsigned NUM_REGS = 13,
  parameter logic [3:0]  READ_CMD = 4'hE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  io_spi_cdce_target_if.slave  spi,
  output logic                 wr_stb,
  output logic [3:0]           wr_addr,
  output logic [27:0]          wr_data,
  output logic                 frame_err,
  output logic                 busy,
  input  logic [3:0]           rd_addr,
  output logic [27:0]          rd_data
);

  localparam logic [4:0] LP_NREG = 5'(NUM_REGS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_COMMIT
  } state_t;

  state_t r_state;
  state_t w_state_nx;

  logic [2:0]  r_sclk_sy;
  logic [1:0]  r_sdat_sy;
  logic [2:0]  r_nen_sy;
  logic [5:0]  r_cnt;
  logic [31:0] r_rx;
  logic [31:0] r_tx;
  logic [3:0]  r_rd_ptr;
  logic        r_rd_pend;
  logic        r_wr_stb;
  logic        r_frame_err;
  logic [3:0]  r_wr_addr;
  logic [27:0] r_wr_data;
  logic [27:0] r_rd_data;
  logic [27:0] r_regs [NUM_REGS];

  logic       w_sclk_rise;
  logic       w_sclk_fall;
  logic       w_nen_fall;
  logic       w_nen_rise;
  logic       w_enter;
  logic       w_len_ok;
  logic [3:0] w_rx_addr;
  logic       w_wr;
  logic       w_rdreq;
  logic       w_err;
  logic       w_ptr_ok;
  logic       w_rd_ok;

  // Stage 3 only exists to give the edge detectors a delayed copy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_sy <= 3'b000;
      r_sdat_sy <= 2'b00;
      r_nen_sy  <= 3'b111;
    end else begin
      r_sclk_sy <= {r_sclk_sy[1:0], spi.spi_sclk};
      r_sdat_sy <= {r_sdat_sy[0], spi.spi_sdata};
      r_nen_sy  <= {r_nen_sy[1:0], spi.spi_n_en};
    end
  end

  assign w_sclk_rise = r_sclk_sy[1] & ~r_sclk_sy[2];
  assign w_sclk_fall = ~r_sclk_sy[1] & r_sclk_sy[2];
  assign w_nen_fall  = ~r_nen_sy[1] & r_nen_sy[2];
  assign w_nen_rise  = r_nen_sy[1] & ~r_nen_sy[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:   if (w_nen_fall) w_state_nx = S_SHIFT;
      S_SHIFT:  if (w_nen_rise) w_state_nx = S_COMMIT;
      S_COMMIT: w_state_nx = S_IDLE;
      default:  w_state_nx = S_IDLE;
    endcase
  end

  assign w_enter   = (r_state == S_IDLE) && w_nen_fall;
  assign w_len_ok  = (r_cnt == 6'd32);
  assign w_rx_addr = r_rx[3:0];
  assign w_wr      = (r_state == S_COMMIT) && w_len_ok
                   && ({1'b0, w_rx_addr} < LP_NREG);
  assign w_rdreq   = (r_state == S_COMMIT) && w_len_ok
                   && (w_rx_addr == READ_CMD);
  assign w_err     = (r_state == S_COMMIT) && !w_len_ok;
  assign w_ptr_ok  = ({1'b0, r_rd_ptr} < LP_NREG);
  assign w_rd_ok   = ({1'b0, rd_addr} < LP_NREG);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_rx        <= '0;
      r_tx        <= '0;
      r_rd_ptr    <= '0;
      r_rd_pend   <= 1'b0;
      r_wr_stb    <= 1'b0;
      r_frame_err <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_rd_data   <= '0;
      for (int i = 0; i < int'(NUM_REGS); i++) r_regs[i] <= '0;
    end else begin
      r_wr_stb    <= w_wr;
      r_frame_err <= w_err;
      r_rd_data   <= w_rd_ok ? r_regs[rd_addr] : '0;
      // Any new frame consumes a pending read, whatever it turns out to be
      if (w_enter) begin
        r_cnt     <= '0;
        r_tx      <= (r_rd_pend && w_ptr_ok)
                   ? {r_regs[r_rd_ptr], r_rd_ptr} : '0;
        r_rd_pend <= 1'b0;
      end else if (r_state == S_SHIFT) begin
        if (w_sclk_rise) begin
          r_rx <= {r_rx[30:0], r_sdat_sy[1]};
          if (r_cnt != 6'd33) r_cnt <= r_cnt + 6'd1;
        end
        if (w_sclk_fall) r_tx <= {r_tx[30:0], 1'b0};
      end
      if (w_wr) begin
        r_regs[w_rx_addr] <= r_rx[31:4];
        r_wr_addr         <= w_rx_addr;
        r_wr_data         <= r_rx[31:4];
      end
      if (w_rdreq) begin
        r_rd_ptr  <= r_rx[7:4];
        r_rd_pend <= 1'b1;
      end
    end
  end

  assign spi.spi_miso = (r_state == S_SHIFT) & r_tx[31];
  assign busy         = (r_state != S_IDLE);
  assign wr_stb       = r_wr_stb;
  assign frame_err    = r_frame_err;
  assign wr_addr      = r_wr_addr;
  assign wr_data      = r_wr_data;
  assign rd_data      = r_rd_data;

endmodule

// File: tb/tb_io_spi_cdce_target.sv
// Scoreboard bench for io_spi_cdce_target: directed SPI frames,
// expected strobes queued at issue time and popped by a monitor.
module tb_io_spi_cdce_target;

  logic        clk;
  logic        rst_n;
  logic        wr_stb;
  logic [3:0]  wr_addr;
  logic [27:0] wr_data;
  logic        frame_err;
  logic        busy;
  logic [3:0]  rd_addr;
  logic [27:0] rd_data;

  io_spi_cdce_target_if spi_if ();

  io_spi_cdce_target dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .spi       (spi_if.slave),
    .wr_stb    (wr_stb),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .frame_err (frame_err),
    .busy      (busy),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data)
  );

  typedef struct {
    bit          err;
    logic [3:0]  a;
    logic [27:0] d;
  } ev_t;

  ev_t         q[$];
  ev_t         m_e;
  logic [27:0] model [13];
  int          n_vec = 0;
  int          n_err = 0;

  logic [31:0] wr_tab [13] = '{
    32'h683C0250, 32'h68000021, 32'h83840002, 32'h68000003,
    32'hE9800004, 32'h101C0BE5, 32'h04BE19A6, 32'h83400157,
    32'h20009D98, 32'h0ABCDEF9, 32'h1111111A, 32'h7654321B,
    32'h0000180C
  };

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endfunction

  // Monitor: every strobe the DUT raises must match the head of the queue
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (wr_stb || frame_err)) begin
      if (q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_event wr_stb=%0b frame_err=%0b exp=none",
                 wr_stb, frame_err);
      end else begin
        m_e = q.pop_front();
        chk("ev_kind", 64'({wr_stb, frame_err}), m_e.err ? 64'd1 : 64'd2);
        if (!m_e.err) begin
          chk("wr_addr", 64'(wr_addr), 64'(m_e.a));
          chk("wr_data", 64'(wr_data), 64'(m_e.d));
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic push_wr(input logic [31:0] w);
    q.push_back('{err: 1'b0, a: w[3:0], d: w[31:4]});
    model[w[3:0]] = w[31:4];
  endtask

  task automatic push_err();
    q.push_back('{err: 1'b1, a: 4'h0, d: 28'h0});
  endtask

  task automatic rd_chk(input int a, input logic [27:0] exp);
    rd_addr = a[3:0];
    @(negedge clk);
    chk("rd_data", 64'(rd_data), 64'(exp));
  endtask

  task automatic send(input logic [63:0] bits, input int n, input bit cm,
                      input logic [31:0] em, input int abort_at);
    logic [31:0] cap;
    cap = '0;
    spi_if.spi_n_en = 1'b0;
    repeat (8) @(negedge clk);
    chk("busy_in_frame", 64'(busy), 64'd1);
    for (int k = 0; k < n; k++) begin
      spi_if.spi_sdata = bits[n-1-k];
      repeat (4) @(negedge clk);
      cap = {cap[30:0], spi_if.spi_miso};
      spi_if.spi_sclk = 1'b1;
      repeat (4) @(negedge clk);
      spi_if.spi_sclk = 1'b0;
      if (abort_at == k + 1) begin
        rst_n = 1'b0;
        spi_if.spi_n_en  = 1'b1;
        spi_if.spi_sdata = 1'b0;
        @(negedge clk);
        chk("rst_outs", {wr_stb, frame_err, busy, spi_if.spi_miso,
                         wr_addr, wr_data, rd_data}, 64'd0);
        for (int i = 0; i < 13; i++) model[i] = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        return;
      end
    end
    repeat (4) @(negedge clk);
    spi_if.spi_n_en  = 1'b1;
    spi_if.spi_sdata = 1'b0;
    repeat (12) @(negedge clk);
    chk("busy_after", 64'(busy), 64'd0);
    if (cm) chk("miso_word", 64'(cap), 64'(em));
  endtask

  initial begin
    rst_n            = 1'b0;
    rd_addr          = 4'h0;
    spi_if.spi_sclk  = 1'b0;
    spi_if.spi_sdata = 1'b0;
    spi_if.spi_n_en  = 1'b1;
    for (int i = 0; i < 13; i++) model[i] = '0;
    repeat (3) @(negedge clk);
    chk("reset_outs", {wr_stb, frame_err, busy, spi_if.spi_miso,
                       wr_addr, wr_data, rd_data}, 64'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 13; i++) begin
      push_wr(wr_tab[i]);
      send(64'(wr_tab[i]), 32, 1'b0, 32'h0, 0);
    end
    rd_chk(0, 28'h683C025);
    rd_chk(12, 28'h0000180);
    for (int i = 0; i < 13; i++) rd_chk(i, model[i]);
    rd_chk(13, 28'h0);
    rd_chk(15, 28'h0);

    send(64'h0000007E, 32, 1'b0, 32'h0, 0);
    send(64'h1234567D, 32, 1'b1, 32'h83400157, 0);
    send(64'h1234567D, 32, 1'b1, 32'h00000000, 0);
    for (int i = 0; i < 13; i++) rd_chk(i, model[i]);

    push_err();
    send(64'(32'h65432103 >> 1), 31, 1'b0, 32'h0, 0);
    push_err();
    send(64'({32'hFFFFFFF3, 2'b11}), 34, 1'b0, 32'h0, 0);
    rd_chk(3, 28'h6800000);

    send(64'h0ABCDE52, 32, 1'b0, 32'h0, 16);
    rd_chk(2, 28'h0);
    rd_chk(7, 28'h0);
    push_wr(32'h0ABCDE52);
    send(64'h0ABCDE52, 32, 1'b0, 32'h0, 0);
    rd_chk(2, 28'h0ABCDE5);

    send(64'h000000FE, 32, 1'b0, 32'h0, 0);
    push_wr(32'h55555555);
    send(64'h55555555, 32, 1'b1, 32'h00000000, 0);
    rd_chk(5, 28'h5555555);

    for (int i = 0; i < 6; i++) begin
      spi_if.spi_sdata = i[0];
      spi_if.spi_sclk  = 1'b1;
      repeat (4) @(negedge clk);
      spi_if.spi_sclk  = 1'b0;
      repeat (4) @(negedge clk);
      chk("idle_quiet", 64'({busy, spi_if.spi_miso}), 64'd0);
    end
    for (int i = 0; i < 13; i++) rd_chk(i, model[i]);

    repeat (20) @(negedge clk);
    chk("sb_drained", 64'(q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
